wired_decode_queue: RTL and testbench
=====================================

WIRED_DECODE_QUEUE -- requirements
Module: wired_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue capacity in single-instruction entries; power of two, minimum 4.
REQ-002 SHALL use `clk`  input  1  as the single clock, with all state updated on its rising edge.
REQ-003 SHALL use `rst`  input  1  as the reset; it is asynchronous and active-high.
REQ-004 SHALL have `flush_i`  input  1  meaning discard all queued entries (backend redirect).
REQ-005 SHALL have `in_valid_i`  input  1  meaning the frontend packet is present.
REQ-006 SHALL have `in_ready_o`  output  1  meaning the queue accepts a packet this cycle.
REQ-007 SHALL have `in_mask_i`  input  2  meaning per-slot valid bits for the incoming packet.
REQ-008 SHALL have `in_pkg_i`  input  2 x pipeline_ctrl_pack_t  meaning the incoming instruction pair, slot 0 older.
REQ-009 SHALL have `out_valid_o`  output  1  meaning at least one entry is presented to rename.
REQ-010 SHALL have `out_ready_i`  input  1  meaning rename consumes the presented pair.
REQ-011 SHALL have `out_mask_o`  output  2  meaning per-slot valid bits of the presented pair.
REQ-012 SHALL have `out_pkg_o`  output  2 x pipeline_ctrl_pack_t  meaning the presented pair, slot 0 oldest.
REQ-013 SHALL have `count_o`  output  log2(DEPTH)+1  meaning current occupancy.

Function
REQ-014 SHALL be a circular buffer with head pointer, tail pointer (log2(DEPTH) bits each, wrapping modulo DEPTH) and an occupancy count register.
REQ-015 SHALL drive in_ready_o = (DEPTH - count) >= 2, computed from the registered count only, with no same-cycle dequeue credit.
REQ-016 SHALL on in_valid_i & in_ready_o & !flush_i write the set slots of in_mask_i to the tail in order, slot 0 before slot 1, compacted with no holes; mask 2'b10 writes in_pkg_i[1] at the tail.
REQ-017 SHALL treat an accepted packet with mask 2'b00 as consumed, leaving the queue state unchanged.
REQ-018 SHALL drive out_valid_o = (count != 0).
REQ-019 SHALL drive out_mask_o = {count >= 2, count >= 1}.
REQ-020 SHALL drive out_pkg_o[0] = entry[head] and out_pkg_o[1] = entry[head+1 mod DEPTH]; an unmasked slot is don't-care.
REQ-021 SHALL on out_valid_o & out_ready_i & !flush_i advance the head by popcount(out_mask_o), i.e. by 1 or 2.
REQ-022 SHALL allow enqueue and dequeue in the same cycle, with count_next = count + enqueued - dequeued.
REQ-023 SHALL have a latency of one cycle: an entry written at edge N is visible on the outputs after edge N, with no empty-queue bypass.
REQ-024 SHALL on flush_i at an edge set count, head and tail to 0; the same-cycle enqueue and dequeue are ignored; out_valid_o = 0 in the following cycle.
REQ-025 SHALL ignore in_pkg_i and in_mask_i when in_valid_i = 0 or in_ready_o = 0, with no state change.
REQ-026 SHALL never let count exceed DEPTH; an overflow is impossible given REQ-015 and SHALL be flagged by a simulation-only assertion.
REQ-027 SHALL handle pointer wrap transparently: a pair may straddle index DEPTH-1 -> 0 on both enqueue and dequeue.
REQ-028 SHALL store the payload with no reset (data-path storage); only control state is reset.

Reset
REQ-029 SHALL while rst = 1, asynchronously force count = 0, head = 0, tail = 0.
REQ-030 SHALL produce reset output values out_valid_o = 0, out_mask_o = 2'b00, in_ready_o = 1, count_o = 0.
REQ-031 SHALL on reset asserted mid-operation discard queued entries immediately; the first accepted packet after deassertion is the first one output.

Verification
REQ-032 SHALL pass the test: reset, push mask 11 (A,B), hold out_ready_i=0 -> next cycle out_valid_o=1, out_mask_o=11, out_pkg_o={B,A}, count_o=2.
REQ-033 SHALL pass the test: push mask 10 (X in slot 1), then mask 01 (Y) -> outputs show slot0=X, slot1=Y, out_mask_o=11.
REQ-034 SHALL pass the test: DEPTH=8, fill with 4 pairs while out_ready_i=0 -> count_o=8, in_ready_o=0; a fifth packet is not accepted; after one pop of 2, count_o=6 and in_ready_o=1.
REQ-035 SHALL pass the test: head=7, count=3, pop with out_ready_i=1 -> entries 7 and 0 are output, head=1, count_o=1, out_mask_o=01.
REQ-036 SHALL pass the test: count=5, flush_i=1 together with a valid push and an out_ready_i pop -> next cycle count_o=0, out_valid_o=0, in_ready_o=1.
REQ-037 SHALL pass the test: count=3, simultaneous push of mask 11 and pop of 2 -> count_o=3, order preserved across 100 random cycles against a reference scoreboard.

Source files
------------

// File: rtl/wired_decode_queue.sv
// Decode queue between fetch and rename: accepts up to two instructions per cycle
// into a circular buffer and presents the two oldest entries to rename.

package wired_decode_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } pipeline_ctrl_pack_t;
endpackage

module wired_decode_queue
    import wired_decode_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [1:0]                    in_mask_i,
    input  pipeline_ctrl_pack_t [1:0]     in_pkg_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [1:0]                    out_mask_o,
    output pipeline_ctrl_pack_t [1:0]     out_pkg_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C     = (PW+1)'(DEPTH);
    localparam logic [PW:0] READY_LIMIT = (PW+1)'(DEPTH - 2);

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [PW:0]   count_reg, count_next;
    logic [PW-1:0] tail_plus1;

    logic          enq_fire, deq_fire;
    logic [1:0]    enq_num, deq_num;
    pipeline_ctrl_pack_t wr_first, wr_second;

    // Payload storage: data path only, never reset.
    pipeline_ctrl_pack_t mem [DEPTH];

    // Ready uses the registered count only, so a full-minus-one queue stalls
    // the frontend even if rename drains in the same cycle.
    assign in_ready_o  = (count_reg <= READY_LIMIT);
    assign out_valid_o = (count_reg != '0);
    assign out_mask_o  = {count_reg >= (PW+1)'(2), count_reg != '0};
    assign count_o     = count_reg;

    assign enq_fire = in_valid_i & in_ready_o & ~flush_i;
    assign deq_fire = out_valid_o & out_ready_i & ~flush_i;
    assign enq_num  = enq_fire ? (2'(in_mask_i[0]) + 2'(in_mask_i[1])) : 2'd0;
    assign deq_num  = deq_fire ? (out_mask_o[1] ? 2'd2 : 2'd1) : 2'd0;

    // Compaction: the oldest valid slot always lands at the tail.
    assign wr_first   = in_mask_i[0] ? in_pkg_i[0] : in_pkg_i[1];
    assign wr_second  = in_pkg_i[1];
    assign tail_plus1 = tail_reg + PW'(1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [PW-1:0] rd_idx;
            assign rd_idx        = head_reg + PW'(gi);
            assign out_pkg_o[gi] = mem[rd_idx];
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_i) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            head_next  = head_reg + PW'(deq_num);
            tail_next  = tail_reg + PW'(enq_num);
            count_next = count_reg + (PW+1)'(enq_num) - (PW+1)'(deq_num);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_num != 2'd0) begin
            mem[tail_reg] <= wr_first;
        end
        if (enq_num == 2'd2) begin
            mem[tail_plus1] <= wr_second;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) count_next <= DEPTH_C);

endmodule

// File: tb/tb_wired_decode_queue.sv
// Self-checking bench for wired_decode_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.

module tb_wired_decode_queue;
    import wired_decode_queue_pkg::*;

    localparam int DEPTH = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [1:0]                in_mask_i;
    pipeline_ctrl_pack_t [1:0] in_pkg_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [1:0]                out_mask_o;
    pipeline_ctrl_pack_t [1:0] out_pkg_o;
    logic [3:0]                count_o;

    int n_vec  = 0;
    int n_fail = 0;

    pipeline_ctrl_pack_t mq[$];

    wired_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_mask_i  (in_mask_i),
        .in_pkg_i   (in_pkg_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_mask_o (out_mask_o),
        .out_pkg_o  (out_pkg_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    function automatic pipeline_ctrl_pack_t mk(input int t);
        pipeline_ctrl_pack_t p;
        p.pc   = 32'h0000_1000 + 32'(t) * 32'd4;
        p.insn = 32'hA500_0000 | 32'(t);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the queue contents as an ordered list of instructions.
    always @(posedge clk or posedge rst) begin : model
        int sz;
        bit rdy;
        if (rst) begin
            mq.delete();
        end else if (flush_i) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            rdy = (DEPTH - sz) >= 2;
            if (out_ready_i && sz > 0) begin
                repeat ((sz >= 2) ? 2 : 1) void'(mq.pop_front());
            end
            if (in_valid_i && rdy) begin
                if (in_mask_i[0]) mq.push_back(in_pkg_i[0]);
                if (in_mask_i[1]) mq.push_back(in_pkg_i[1]);
            end
        end
    end

    always @(negedge clk) begin : compare
        int sz;
        if (!rst) begin
            sz = mq.size();
            check("cmp_count", 64'(count_o), 64'(sz));
            check("cmp_valid", 64'(out_valid_o), 64'(sz != 0));
            check("cmp_mask", 64'(out_mask_o), {62'd0, sz >= 2, sz >= 1});
            check("cmp_ready", 64'(in_ready_o), 64'((DEPTH - sz) >= 2));
            if (sz >= 1) check("cmp_pkg0", out_pkg_o[0], mq[0]);
            if (sz >= 2) check("cmp_pkg1", out_pkg_o[1], mq[1]);
        end
    end

    task automatic drive(input logic v, input logic [1:0] m, input int t0, input int t1,
                         input logic ordy, input logic fl);
        in_valid_i  = v;
        in_mask_i   = m;
        in_pkg_i[0] = mk(t0);
        in_pkg_i[1] = mk(t1);
        out_ready_i = ordy;
        flush_i     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_mask", 64'(out_mask_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);
        rst = 1'b0;

        // Pair push, held at the output
        drive(1'b1, 2'b11, 1, 2, 1'b0, 1'b0);
        tick(); idle();
        check("pair_valid", 64'(out_valid_o), 64'd1);
        check("pair_mask", 64'(out_mask_o), 64'd3);
        check("pair_pkg0", out_pkg_o[0], mk(1));
        check("pair_pkg1", out_pkg_o[1], mk(2));
        check("pair_count", 64'(count_o), 64'd2);
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1); tick(); idle();

        // Compaction: mask 10 then mask 01
        drive(1'b1, 2'b10, 99, 10, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b01, 11, 98, 1'b0, 1'b0); tick(); idle();
        check("cmp_x_slot0", out_pkg_o[0], mk(10));
        check("cmp_y_slot1", out_pkg_o[1], mk(11));
        check("cmp_xy_mask", 64'(out_mask_o), 64'd3);
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1); tick(); idle();

        // Fill to DEPTH, blocked fifth push, then one pop of two
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 20 + 2*i, 21 + 2*i, 1'b0, 1'b0); tick();
        end
        idle();
        check("full_count", 64'(count_o), 64'd8);
        check("full_ready", 64'(in_ready_o), 64'd0);
        drive(1'b1, 2'b11, 28, 29, 1'b0, 1'b0); tick(); idle();
        check("blocked_count", 64'(count_o), 64'd8);
        drive(1'b0, 2'b00, 0, 0, 1'b1, 1'b0); tick(); idle();
        check("pop_count", 64'(count_o), 64'd6);
        check("pop_ready", 64'(in_ready_o), 64'd1);
        check("pop_pkg0", out_pkg_o[0], mk(22));
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1); tick(); idle();

        // Walk head to 7, then straddle the wrap with three entries
        drive(1'b1, 2'b01, 30, 0, 1'b0, 1'b0); tick();
        drive(1'b0, 2'b00, 0, 0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 31 + 2*i, 32 + 2*i, 1'b0, 1'b0); tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 0, 0, 1'b1, 1'b0); tick();
        end
        drive(1'b1, 2'b11, 40, 41, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b01, 42, 0, 1'b0, 1'b0); tick(); idle();
        check("wrap_count", 64'(count_o), 64'd3);
        check("wrap_pkg0", out_pkg_o[0], mk(40));
        check("wrap_pkg1", out_pkg_o[1], mk(41));
        drive(1'b0, 2'b00, 0, 0, 1'b1, 1'b0); tick(); idle();
        check("wrap_pop_count", 64'(count_o), 64'd1);
        check("wrap_pop_mask", 64'(out_mask_o), 64'd1);
        check("wrap_pop_pkg0", out_pkg_o[0], mk(42));

        // Flush beats simultaneous push and pop
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1); tick();
        drive(1'b1, 2'b11, 50, 51, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b11, 52, 53, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b01, 54, 0, 1'b0, 1'b0); tick();
        check("pre_flush_count", 64'(count_o), 64'd5);
        drive(1'b1, 2'b11, 55, 56, 1'b1, 1'b1); tick(); idle();
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_ready", 64'(in_ready_o), 64'd1);

        // Simultaneous push 11 and pop 2 at count 3
        drive(1'b1, 2'b11, 60, 61, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b01, 62, 0, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b11, 63, 64, 1'b1, 1'b0); tick(); idle();
        check("simul_count", 64'(count_o), 64'd3);
        check("simul_pkg0", out_pkg_o[0], mk(62));
        check("simul_pkg1", out_pkg_o[1], mk(63));

        for (int i = 0; i < 100; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 100 + 2*i, 101 + 2*i,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            tick();
        end

        // Asynchronous reset mid-operation
        drive(1'b1, 2'b11, 400, 401, 1'b0, 1'b0); tick(); idle();
        #2 rst = 1'b1;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(out_valid_o), 64'd0);
        drive(1'b1, 2'b11, 500, 501, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick(); idle();
        check("post_rst_pkg0", out_pkg_o[0], mk(500));
        check("post_rst_count", 64'(count_o), 64'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
